// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
//
// Purpose:
//   Controller that turns an attached dual-port RAM (registered read port,
//   read-before-write on an address collision) into a synchronous FIFO.
//   It owns the write/read pointers, the occupancy count and the full/empty
//   flags, and drives the RAM's write and read ports combinationally from
//   the accepted push/pop.
//
// Optional feature:
//   FIFO_ERR_FLAGS_EN  when defined, sticky overflow/underflow error flags are
//                      built; when undefined both outputs are tied low and no
//                      error logic exists.
//
// Parameters:
//   RAM_WIDTH   data word width (must match the RAM)
//   RAM_DEPTH   number of entries (must equal 2**ADDR_SIZE)
//   ADDR_SIZE   pointer / RAM address width
//
// Ports:
//   clk           single clock, all logic on posedge
//   rst           synchronous active-high reset (also feeds the RAM's rst)
//   push          producer write request
//   push_data     word to write
//   pop           consumer read request
//   full          FIFO holds RAM_DEPTH words
//   empty         FIFO holds no words
//   count         occupancy, 0..RAM_DEPTH
//   pop_data      popped word, straight from ram_data_out
//   pop_valid     pop_data is valid this cycle
//   overflow      sticky: push attempted and rejected
//   underflow     sticky: pop attempted while empty
//   ram_wr_enb    RAM write enable
//   ram_wr_addr   RAM write address
//   ram_data_in   RAM write data
//   ram_rd_enb    RAM read enable
//   ram_rd_addr   RAM read address
//   ram_data_out  RAM registered read data
// -----------------------------------------------------------------------------
module sync_fifo_ctrl #(
   parameter int RAM_WIDTH = 8,
   parameter int RAM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [RAM_WIDTH-1:0] push_data,
   input  logic                 pop,
   output logic                 full,
   output logic                 empty,
   output logic [ADDR_SIZE:0]   count,
   output logic [RAM_WIDTH-1:0] pop_data,
   output logic                 pop_valid,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 ram_wr_enb,
   output logic [ADDR_SIZE-1:0] ram_wr_addr,
   output logic [RAM_WIDTH-1:0] ram_data_in,
   output logic                 ram_rd_enb,
   output logic [ADDR_SIZE-1:0] ram_rd_addr,
   input  logic [RAM_WIDTH-1:0] ram_data_out
);

   // Occupancy value that means "full"; count is one bit wider than the
   // pointers so that full and empty are distinguishable.
   localparam logic [ADDR_SIZE:0]   DEPTH_C     = (ADDR_SIZE+1)'(RAM_DEPTH);
   localparam logic [ADDR_SIZE:0]   CNT_ZERO_C  = '0;
   localparam logic [ADDR_SIZE:0]   CNT_ONE_C   = (ADDR_SIZE+1)'(1);
   localparam logic [ADDR_SIZE-1:0] PTR_ZERO_C  = '0;
   localparam logic [ADDR_SIZE-1:0] PTR_ONE_C   = (ADDR_SIZE)'(1);

   // Pointer arithmetic relies on natural wrap, so the depth must be a
   // power of two matching the address width.
   generate
      if (RAM_DEPTH != (1 << ADDR_SIZE)) begin : g_bad_depth
         $error("sync_fifo_ctrl: RAM_DEPTH must equal 2**ADDR_SIZE");
      end
   endgenerate

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [ADDR_SIZE-1:0] wr_ptr_q,    wr_ptr_d;
   logic [ADDR_SIZE-1:0] rd_ptr_q,    rd_ptr_d;
   logic [ADDR_SIZE:0]   count_q,     count_d;
   logic                 full_q,      full_d;
   logic                 empty_q,     empty_d;
   logic                 pop_valid_q, pop_valid_d;

   logic                 push_acc_s;
   logic                 pop_acc_s;

   // Accept decisions. A pop can only be taken when something is stored;
   // a push is taken when there is room, or when a simultaneous accepted pop
   // frees the slot being written (full case: wr_ptr == rd_ptr and the RAM
   // returns the old word before the new one lands).
   always_comb begin
      pop_acc_s  = pop & ~empty_q;
      push_acc_s = push & (~full_q | pop_acc_s);
   end

   // Next-state for pointers, occupancy, flags and the pop-valid pipeline.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      pop_valid_d = pop_acc_s;

      if (push_acc_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE_C;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_acc_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE_C;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      // Simultaneous push and pop leave the occupancy unchanged.
      case ({push_acc_s, pop_acc_s})
         2'b10:   count_d = count_q + CNT_ONE_C;
         2'b01:   count_d = count_q - CNT_ONE_C;
         default: count_d = count_q;
      endcase

      // Flags are decoded from the next count and registered, so they never
      // depend combinationally on push/pop in the cycle they are observed.
      full_d  = (count_d == DEPTH_C);
      empty_d = (count_d == CNT_ZERO_C);
   end

   // Main state register with synchronous reset; reset empties the FIFO and
   // squashes any pop accepted in the reset cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= PTR_ZERO_C;
         rd_ptr_q    <= PTR_ZERO_C;
         count_q     <= CNT_ZERO_C;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         pop_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         pop_valid_q <= pop_valid_d;
      end
   end

   // -------------------------------------------------------------------------
   // Optional sticky error flags
   // -------------------------------------------------------------------------
`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q,  overflow_d;
   logic underflow_q, underflow_d;

   // Error flags accumulate until reset: a push that was not taken, or a pop
   // issued while the FIFO was empty.
   always_comb begin
      overflow_d  = overflow_q  | (push & ~push_acc_s);
      underflow_d = underflow_q | (pop & empty_q);
   end

   // Error flag registers, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign full      = full_q;
   assign empty     = empty_q;
   assign count     = count_q;
   assign pop_valid = pop_valid_q;

   // The RAM's read port is itself registered, so the data lines up with
   // pop_valid without any extra staging here.
   assign pop_data  = ram_data_out;

   // RAM ports are driven in the same cycle as the accept decision.
   assign ram_wr_enb  = push_acc_s;
   assign ram_wr_addr = wr_ptr_q;
   assign ram_data_in = push_data;
   assign ram_rd_enb  = pop_acc_s;
   assign ram_rd_addr = rd_ptr_q;

endmodule
